needwun_mul_pipe_hs: RTL and testbench

//  Parametrised pipelined multiplier for the HLS datapath, successor to the fixed-width DSP48 multiplier wrappers.

---
 rtl/needwun_mul_pipe_hs.sv | 141 ++++++++++++++
 tb/tb_needwun_mul_pipe_hs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/needwun_mul_pipe_hs.sv
// rtl/needwun_mul_pipe_hs.sv - pipelined multiplier with valid/ready handshake and full-pipeline stall
// Optional accumulate (MAC) stage and acc_clr input are built when NEEDWUN_MUL_ACC_EN is defined.
module needwun_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 15,
  parameter int DOUT_WIDTH  = 29,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
`ifdef NEEDWUN_MUL_ACC_EN
  input  logic                  acc_clr,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int FW = DIN0_WIDTH + DIN1_WIDTH;

  // The instance tag has no functional role; it is only kept visible for netlist inspection.
  logic [31:0] unused_id;
  assign unused_id = ID;

  logic                  adv;
  logic                  accept;
  logic [NUM_STAGE:1]    vld_q;
  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic [DOUT_WIDTH-1:0] prod_q [2:NUM_STAGE];

  logic                  a_sign;
  logic                  b_sign;
  logic [FW-1:0]         a_ext;
  logic [FW-1:0]         b_ext;
  logic [FW-1:0]         p_full;
  logic [DOUT_WIDTH-1:0] p_sized;

  // A single advance strobe moves every stage together; bubbles travel with the data.
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // Operands are widened to the full product width so one unsigned multiply gives the exact result.
  assign a_sign = (DIN0_SIGNED != 0) && a_q[DIN0_WIDTH-1];
  assign b_sign = (DIN1_SIGNED != 0) && b_q[DIN1_WIDTH-1];
  assign a_ext  = {{DIN1_WIDTH{a_sign}}, a_q};
  assign b_ext  = {{DIN0_WIDTH{b_sign}}, b_q};
  assign p_full = a_ext * b_ext;

  generate
    if (DOUT_WIDTH < FW) begin : g_trunc
      logic [FW-DOUT_WIDTH-1:0] unused_p_hi;
      assign unused_p_hi = p_full[FW-1:DOUT_WIDTH];
      assign p_sized     = p_full[DOUT_WIDTH-1:0];
    end else if (DOUT_WIDTH == FW) begin : g_exact
      assign p_sized = p_full;
    end else begin : g_extend
      // A product involving any signed operand is itself signed, so its MSB is the sign.
      logic p_sign;
      assign p_sign  = ((DIN0_SIGNED != 0) || (DIN1_SIGNED != 0)) && p_full[FW-1];
      assign p_sized = {{(DOUT_WIDTH-FW){p_sign}}, p_full};
    end
  endgenerate

  // Valid chain: stage 1 records whether this advance accepted an op, later stages shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[NUM_STAGE-1:1], accept};
    end
  end

  // Data path: operands in stage 1, product from stage 2 on; a stage only loads behind a valid op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      for (int s = 2; s <= NUM_STAGE; s++) begin
        prod_q[s] <= '0;
      end
    end else if (adv) begin
      if (accept) begin
        a_q <= din0;
        b_q <= din1;
      end
      if (vld_q[1]) begin
        prod_q[2] <= p_sized;
      end
      for (int s = 3; s <= NUM_STAGE; s++) begin
        if (vld_q[s-1]) begin
          prod_q[s] <= prod_q[s-1];
        end
      end
    end
  end

`ifdef NEEDWUN_MUL_ACC_EN
  logic [NUM_STAGE:1]    clr_q;
  logic                  acc_vld_q;
  logic [DOUT_WIDTH-1:0] acc_q;

  // Clear flag rides alongside its op so it reaches the accumulator in the same advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_q <= '0;
    end else if (adv) begin
      clr_q <= {clr_q[NUM_STAGE-1:1], acc_clr & accept};
    end
  end

  // Accumulator stage: each valid op adds its product (wrapping), optionally starting a new chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_vld_q <= 1'b0;
      acc_q     <= '0;
    end else if (adv) begin
      acc_vld_q <= vld_q[NUM_STAGE];
      if (vld_q[NUM_STAGE]) begin
        acc_q <= (clr_q[NUM_STAGE] ? '0 : acc_q) + prod_q[NUM_STAGE];
      end
    end
  end

  assign out_valid = acc_vld_q;
  assign dout      = acc_q;
`else
  assign out_valid = vld_q[NUM_STAGE];
  assign dout      = prod_q[NUM_STAGE];
`endif

endmodule

// File: tb/tb_needwun_mul_pipe_hs.sv
// tb/tb_needwun_mul_pipe_hs.sv - scoreboard bench for needwun_mul_pipe_hs (default and signed 8x8 instances)
module tb_needwun_mul_pipe_hs;

`ifdef NEEDWUN_MUL_ACC_EN
  localparam int LAT = 5;
  localparam logic [63:0] E6_1 = 64'd42;
`else
  localparam int LAT = 4;
  localparam logic [63:0] E6_1 = 64'd30;
`endif
  localparam logic [63:0] MASK_M = (64'd1 << 29) - 64'd1;
  localparam logic [63:0] MASK_S = 64'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [14:0] din1;
  logic [7:0]  din0s;
  logic [7:0]  din1s;
`ifdef NEEDWUN_MUL_ACC_EN
  logic        acc_clr;
`endif
  logic        in_ready, out_valid;
  logic [28:0] dout;
  logic        in_ready_s, out_valid_s;
  logic [15:0] dout_s;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] q_m[$];
  logic [63:0] q_s[$];
  logic [63:0] acc_m = '0;
  logic [63:0] acc_s = '0;
  bit          hold_m = 0, hold_s = 0;
  logic [63:0] held_m, held_s;

  always #5 clk = ~clk;

  needwun_mul_pipe_hs u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
`ifdef NEEDWUN_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  needwun_mul_pipe_hs #(
    .ID(2), .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .NUM_STAGE(4)
  ) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0s), .din1(din1s),
`ifdef NEEDWUN_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic miss(input string name);
    n_chk++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // One cycle of stimulus; expected results are modelled and queued when the op is accepted.
  task automatic step(input bit v, input logic [13:0] a, input logic [14:0] b, input bit clr,
                      input bit c, input bit ordy, input bit fx_m, input logic [63:0] fv_m,
                      input bit fx_s, input logic [63:0] fv_s);
    logic signed [7:0] sa8, sb8;
    longint pm, ps;
    @(negedge clk);
    in_valid = v; din0 = a; din1 = b; din0s = a[7:0]; din1s = b[7:0];
    ce = c; out_ready = ordy;
`ifdef NEEDWUN_MUL_ACC_EN
    acc_clr = clr;
`endif
    #2;
    if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
    if (!ce) check("ce_in_ready", in_ready, 0);
    if (in_valid && in_ready) begin
      pm = longint'(a) * longint'(b);
      acc_m = ((clr ? 64'd0 : acc_m) + 64'(pm)) & MASK_M;
`ifdef NEEDWUN_MUL_ACC_EN
      q_m.push_back(fx_m ? fv_m : acc_m);
`else
      q_m.push_back(fx_m ? fv_m : (64'(pm) & MASK_M));
`endif
    end
    if (in_valid && in_ready_s) begin
      sa8 = a[7:0]; sb8 = b[7:0];
      ps = longint'(sa8) * longint'(sb8);
      acc_s = ((clr ? 64'd0 : acc_s) + 64'(ps)) & MASK_S;
`ifdef NEEDWUN_MUL_ACC_EN
      q_s.push_back(fx_s ? fv_s : acc_s);
`else
      q_s.push_back(fx_s ? fv_s : (64'(ps) & MASK_S));
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
  endtask

  // Monitor: pops and compares on each transfer, and checks that a stalled output is held.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (hold_m) begin check("hold_valid", out_valid, 1); check("hold_dout", dout, held_m); end
      if (hold_s) begin check("hold_valid_s", out_valid_s, 1); check("hold_dout_s", dout_s, held_s); end
      if (out_valid && out_ready && ce) begin
        if (q_m.size() == 0) miss("extra_output");
        else check("dout", dout, q_m.pop_front());
      end
      if (out_valid_s && out_ready && ce) begin
        if (q_s.size() == 0) miss("extra_output_s");
        else check("dout_s", dout_s, q_s.pop_front());
      end
      hold_m = out_valid && !(out_ready && ce);
      hold_s = out_valid_s && !(out_ready && ce);
      held_m = 64'(dout);
      held_s = 64'(dout_s);
    end else begin
      hold_m = 0;
      hold_s = 0;
    end
  end

  initial begin
    bit found;
    int e;
    reset = 1'b0; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din0 = '0; din1 = '0; din0s = '0; din1s = '0;
`ifdef NEEDWUN_MUL_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_out_valid_s", out_valid_s, 0);
    check("rst_dout_s", dout_s, 0);
    reset = 1'b1;

    // Max unsigned operands, exact latency.
    step(1, 14'd16383, 15'd32767, 1, 1, 1, 1, 64'h1FFF4001, 0, 0);
    for (int k = 1; k <= LAT; k++) begin
      step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      check("latency", out_valid, (k == LAT));
    end
    idle(2);

    // Back-to-back ops: one result per cycle, in order.
    e = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 14'(i), 15'(i + 1), 0, 1, 1, 0, 0, 0, 0);
      check("b2b_in_ready", in_ready, 1);
      check("b2b_valid", out_valid, (e >= LAT && e <= LAT + 7));
      e++;
    end
    for (int j = 0; j < LAT + 4; j++) begin
      step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      check("b2b_valid", out_valid, (e >= LAT && e <= LAT + 7));
      e++;
    end

    // Back-pressure with ops in flight.
    for (int i = 0; i < 3; i++)
      step(1, 14'($urandom_range(0, 16383)), 15'($urandom_range(0, 32767)), 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 14'($urandom_range(0, 16383)), 15'($urandom_range(0, 32767)), 0, 1, 0, 0, 0, 0, 0);
    idle(LAT + 6);

    // Signed 8x8 corner case.
    step(1, 14'h0080, 15'h007F, 1, 1, 1, 0, 0, 1, 64'hC080);
    idle(LAT + 2);

    // Accumulate chain with ce=0 gaps (plain products when accumulation is not built).
    step(1, 14'd3, 15'd4, 1, 1, 1, 1, 64'd12, 0, 0);
    step(1, 14'd9, 15'd9, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 14'd5, 15'd6, 0, 1, 1, 1, E6_1, 0, 0);
    step(1, 14'd7, 15'd7, 0, 0, 1, 0, 0, 0, 0);
    step(1, 14'd2, 15'd2, 1, 1, 1, 1, 64'd4, 0, 0);
    idle(LAT + 4);

    // Random traffic with ce gaps and back-pressure.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)), 15'($urandom_range(0, 32767)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
           0, 0, 0, 0);

    // Asynchronous reset while a result is waiting at the output.
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1, 14'($urandom_range(0, 16383)), 15'($urandom_range(0, 32767)), 0, 1, 0, 0, 0, 0, 0);
      if (out_valid) found = 1;
    end
    if (!found) miss("reset_wait_timeout");
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_valid_s", out_valid_s, 0);
    check("async_rst_dout_s", dout_s, 0);
    q_m.delete(); q_s.delete();
    acc_m = '0; acc_s = '0;
    #1 reset = 1'b1;
    step(1, 14'd100, 15'd200, 0, 1, 1, 0, 0, 0, 0);
    step(1, 14'd12345, 15'd23456, 0, 1, 1, 0, 0, 0, 0);
    idle(LAT + 6);

    check("queue_empty", q_m.size(), 0);
    check("queue_empty_s", q_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
